sargantana_set_ram_ctrl: RTL and testbench

//  Sequencer/arbiter in front of one single-port set RAM (1-cycle sync read, write-or-read per req).

---
 rtl/sargantana_set_ram_ctrl.sv | 104 ++++++++++
 tb/tb_sargantana_set_ram_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_set_ram_ctrl.sv
// Single-port set RAM sequencer: clears all entries after reset or flush and
// arbitrates the port between refill writes and lookup reads (write wins).
module sargantana_set_ram_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_gnt_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_gnt_o,
    output logic                  busy_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_gnt_o;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ram_req_o  = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        rd_gnt_o   = 1'b0;
        wr_gnt_o   = 1'b0;
        busy_o     = 1'b0;
        if (rst_i) begin
            busy_o = 1'b1;
        end else begin
            case (state_q)
                INIT, FLUSH: begin
                    // Clear sweep: one zero write per cycle, requests and flush ignored
                    busy_o     = 1'b1;
                    ram_req_o  = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_addr_o = cnt_q;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (flush_i) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else if (wr_req_i) begin
                        wr_gnt_o   = 1'b1;
                        ram_req_o  = 1'b1;
                        ram_we_o   = 1'b1;
                        ram_addr_o = wr_addr_i;
                        ram_data_o = wr_data_i;
                    end else if (rd_req_i) begin
                        rd_gnt_o   = 1'b1;
                        ram_req_o  = 1'b1;
                        ram_addr_o = rd_addr_i;
                    end
                end
                default: begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rd_valid_o = rd_valid_q & ~rst_i;
    assign rd_data_o  = rd_valid_o ? ram_data_i : '0;

endmodule

// File: tb/tb_sargantana_set_ram_ctrl.sv
// Directed bench for sargantana_set_ram_ctrl with a behavioural 1-cycle sync RAM.
module tb_sargantana_set_ram_ctrl;

    localparam int DW    = 256;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, flush, rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_gnt, rd_valid, wr_gnt, busy;
    logic [DW-1:0] rd_data;
    logic          ram_req, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    localparam logic [DW-1:0] D_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] D_3C = {32{8'h3C}};
    localparam logic [DW-1:0] D_11 = {32{8'h11}};
    localparam logic [DW-1:0] D_22 = {32{8'h22}};
    localparam logic [DW-1:0] D_33 = {32{8'h33}};

    always #5 clk = ~clk;

    sargantana_set_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
        .busy_o(busy), .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        rd_addr = 6'd9; wr_addr = 6'd9; wr_data = D_3C;
        #1;
        checks++;
        if (busy !== 1'b1 || ram_req !== 1'b0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b req=%b rgnt=%b wgnt=%b rval=%b want 1 0 0 0 0",
                     busy, ram_req, rd_gnt, wr_gnt, rd_valid);
        end
        step();
        rst = 1'b0; flush = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin rd_req = 1'b0; wr_req = 1'b0; flush = 1'b0; end
            #1;
            checks++;
            if (busy !== 1'b1 || ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i) ||
                ram_wdata !== '0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
                errors++;
                $display("FAIL init_sweep i=%0d busy=%b req=%b we=%b addr=%0d gnts=%b%b want addr=%0d we=1 no grants",
                         i, busy, ram_req, ram_we, ram_addr, rd_gnt, wr_gnt, i);
            end
            step();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || ram_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b req=%b want 0 0", busy, ram_req);
        end
    endtask

    task automatic test_wr_rd_same_cycle();
        wr_req = 1'b1; wr_addr = 6'd5; wr_data = D_A5;
        rd_req = 1'b1; rd_addr = 6'd5;
        #1;
        checks++;
        if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 6'd5 || ram_wdata !== D_A5) begin
            errors++;
            $display("FAIL wr_priority wgnt=%b rgnt=%b we=%b addr=%0d want 1 0 1 5", wr_gnt, rd_gnt, ram_we, ram_addr);
        end
        step();
        wr_req = 1'b0;
        #1;
        checks++;
        if (rd_gnt !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 6'd5 || ram_wdata !== '0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_after_wr_gnt rgnt=%b we=%b addr=%0d rval=%b want 1 0 5 0", rd_gnt, ram_we, ram_addr, rd_valid);
        end
        step();
        rd_req = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== D_A5) begin
            errors++;
            $display("FAIL rd_after_wr_data rval=%b data=%h want 1 %h", rd_valid, rd_data, D_A5);
        end
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL rd_valid_drop rval=%b data=%h want 0 0", rd_valid, rd_data);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; rd_req = 1'b1; rd_addr = 6'd5; wr_req = 1'b1; wr_addr = 6'd7; wr_data = D_3C;
        #1;
        checks++;
        if (ram_req !== 1'b0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_wins req=%b rgnt=%b wgnt=%b busy=%b want 0 0 0 0", ram_req, rd_gnt, wr_gnt, busy);
        end
        step();
        flush = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i) ||
                ram_wdata !== '0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
                errors++;
                $display("FAIL flush_sweep i=%0d busy=%b we=%b addr=%0d gnts=%b%b want addr=%0d", i, busy, ram_we, ram_addr, rd_gnt, wr_gnt, i);
            end
            step();
        end
        #1;
        checks++;
        if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || ram_addr !== 6'd7) begin
            errors++;
            $display("FAIL flush_pending_wr wgnt=%b rgnt=%b addr=%0d want 1 0 7", wr_gnt, rd_gnt, ram_addr);
        end
        step();
        wr_req = 1'b0;
        #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_rd_gnt rgnt=%b want 1", rd_gnt);
        end
        step();
        rd_req = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== '0) begin
            errors++;
            $display("FAIL flush_cleared rval=%b data=%h want 1 0", rd_valid, rd_data);
        end
        step();
    endtask

    task automatic test_flush_held();
        flush = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || ram_addr !== AW'(i) || ram_we !== 1'b1) begin
                errors++;
                $display("FAIL held_sweep1 i=%0d busy=%b addr=%0d want 1 %0d", i, busy, ram_addr, i);
            end
            step();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || ram_req !== 1'b0) begin
            errors++;
            $display("FAIL held_idle busy=%b req=%b want 0 0", busy, ram_req);
        end
        step();
        flush = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || ram_addr !== AW'(i) || ram_we !== 1'b1) begin
                errors++;
                $display("FAIL held_sweep2 i=%0d busy=%b addr=%0d want 1 %0d", i, busy, ram_addr, i);
            end
            step();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || ram_req !== 1'b0) begin
            errors++;
            $display("FAIL held_single_again busy=%b req=%b want 0 0", busy, ram_req);
        end
    endtask

    task automatic test_reset_mid_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 30; i++) step();
        #1;
        checks++;
        if (ram_addr !== 6'd30 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midflush_pos addr=%0d busy=%b want 30 1", ram_addr, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ram_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midflush_rst req=%b busy=%b want 0 1", ram_req, busy);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'(i)) begin
                errors++;
                $display("FAIL restart_sweep i=%0d addr=%0d busy=%b want %0d 1", i, ram_addr, busy, i);
            end
            step();
        end
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_drops_read();
        rd_req = 1'b1; rd_addr = 6'd2;
        #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL drop_rd_gnt rgnt=%b want 1", rd_gnt);
        end
        step();
        rd_req = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL drop_rd_valid rval=%b data=%h want 0 0", rd_valid, rd_data);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || ram_addr !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_rd_after rval=%b addr=%0d busy=%b want 0 0 1", rd_valid, ram_addr, busy);
        end
        for (int i = 0; i < DEPTH; i++) step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [3];
        d[0] = D_11; d[1] = D_22; d[2] = D_33;
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = AW'(i + 1); wr_data = d[i];
            #1;
            checks++;
            if (wr_gnt !== 1'b1 || ram_addr !== AW'(i + 1)) begin
                errors++;
                $display("FAIL b2b_wr i=%0d wgnt=%b addr=%0d want 1 %0d", i, wr_gnt, ram_addr, i + 1);
            end
            step();
        end
        wr_req = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = AW'(i + 1);
            #1;
            checks++;
            if (rd_gnt !== 1'b1 || ram_addr !== AW'(i + 1) || rd_valid !== (i != 0) ||
                (i != 0 && rd_data !== d[i-1])) begin
                errors++;
                $display("FAIL b2b_rd i=%0d rgnt=%b addr=%0d rval=%b data=%h", i, rd_gnt, ram_addr, rd_valid, rd_data);
            end
            step();
        end
        // Last read returns while flush is being taken in the same cycle
        rd_req = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== D_33 || ram_req !== 1'b0 || rd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last rval=%b data=%h req=%b want 1 %h 0", rd_valid, rd_data, ram_req, D_33);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_tail rval=%b busy=%b want 0 1", rd_valid, busy);
        end
        for (int i = 0; i < DEPTH; i++) step();
    endtask

    initial begin
        ram_rdata = '0;
        test_reset();
        test_wr_rd_same_cycle();
        test_flush();
        test_flush_held();
        test_reset_mid_flush();
        test_reset_drops_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
